// File: rtl/elevator_floor_display_pkg.sv
// Shared types and 7-segment constants for the elevator floor indicator.
package elevator_pkg;

    typedef enum logic [1:0] {
        OFF         = 2'd0,
        STEADY      = 2'd1,
        PULSE_BLINK = 2'd2,
        HOLD_BLINK  = 2'd3
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] w_seg;
        case (digit)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            default: w_seg = SEG_DASH;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/elevator_floor_display_tick_divider.sv
// Free-running 0..DIV-1 counter; tick is high on the terminal count while enabled.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;

    // Counter: clear has priority, wraps at DIV-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == W'(DIV - 1)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign tick = en && (r_cnt == W'(DIV - 1));

endmodule

// File: rtl/elevator_floor_display.sv
// Two-digit multiplexed floor indicator with arrival blink and alarm blink.
module elevator_floor_display
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 3,
    parameter int FLOOR_W     = 2,
    parameter int FLOOR_BASE  = 1,
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_DIV   = 25000000,
    parameter int BLINK_COUNT = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               arrive,
    input  logic               alarm,
    output logic [6:0]         seg,
    output logic [1:0]         an,
    output logic               blinking
);

    localparam int DARK_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

    logic [FLOOR_W-1:0] r_floor_q;
    state_t             r_state;
    logic               r_digit_sel;
    logic               r_phase;
    logic [DARK_W-1:0]  r_dark_cnt;
    logic [6:0]         r_seg;
    logic [1:0]         r_an;
    logic               r_blinking;

    state_t             w_state_nx;
    logic               w_restart;
    logic               w_blink_nx;
    logic               w_blink_clr;
    logic               w_scan_tick;
    logic               w_blink_tick;
    logic               w_phase_nx;
    logic [DARK_W-1:0]  w_dark_nx;
    logic               w_digit_sel_nx;
    logic               w_invalid;
    logic [6:0]         w_value;
    logic [6:0]         w_tens_seg;
    logic [6:0]         w_ones_seg;
    logic [6:0]         w_seg_nx;
    logic [1:0]         w_an_nx;

    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clock (clock),
        .reset (reset),
        .en    (r_state != OFF),
        .clr   (w_state_nx == OFF),
        .tick  (w_scan_tick)
    );

    tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
        .clock (clock),
        .reset (reset),
        .en    ((r_state == PULSE_BLINK) || (r_state == HOLD_BLINK)),
        .clr   (w_blink_clr),
        .tick  (w_blink_tick)
    );

    // Next state: enable=0 beats alarm, alarm beats arrive.
    always_comb begin
        w_state_nx = r_state;
        w_restart  = 1'b0;
        if (!enable) begin
            w_state_nx = OFF;
        end else begin
            case (r_state)
                OFF:         w_state_nx = STEADY;
                STEADY: begin
                    if (alarm)       w_state_nx = HOLD_BLINK;
                    else if (arrive) w_state_nx = PULSE_BLINK;
                    else             w_state_nx = STEADY;
                end
                PULSE_BLINK: begin
                    if (alarm) begin
                        w_state_nx = HOLD_BLINK;
                    end else if (arrive) begin
                        w_state_nx = PULSE_BLINK;
                        w_restart  = 1'b1;
                    end else if (w_blink_tick && r_phase &&
                                 (r_dark_cnt == DARK_W'(BLINK_COUNT - 1))) begin
                        w_state_nx = STEADY;
                    end else begin
                        w_state_nx = PULSE_BLINK;
                    end
                end
                HOLD_BLINK:  w_state_nx = alarm ? HOLD_BLINK : STEADY;
                default:     w_state_nx = OFF;
            endcase
        end
    end

    // Blink phase bookkeeping; any entry, exit or restart starts from a lit phase.
    always_comb begin
        w_blink_nx  = (w_state_nx == PULSE_BLINK) || (w_state_nx == HOLD_BLINK);
        w_blink_clr = !w_blink_nx || (w_state_nx != r_state) || w_restart;
        w_phase_nx  = r_phase;
        w_dark_nx   = r_dark_cnt;
        if (w_blink_clr) begin
            w_phase_nx = 1'b0;
            w_dark_nx  = '0;
        end else if (w_blink_tick) begin
            w_phase_nx = ~r_phase;
            if (r_phase && (r_state == PULSE_BLINK)) begin
                w_dark_nx = r_dark_cnt + DARK_W'(1);
            end else begin
                w_dark_nx = r_dark_cnt;
            end
        end else begin
            w_phase_nx = r_phase;
            w_dark_nx  = r_dark_cnt;
        end
    end

    // Digit decode and output selection from the next-cycle scan/blink view.
    always_comb begin
        w_invalid  = (int'(r_floor_q) >= NUM_FLOORS);
        w_value    = 7'(int'(r_floor_q) + FLOOR_BASE);
        w_tens_seg = SEG_BLANK;
        w_ones_seg = SEG_DASH;
        if (w_invalid) begin
            w_tens_seg = SEG_DASH;
            w_ones_seg = SEG_DASH;
        end else begin
            w_ones_seg = digit_to_seg(4'(w_value % 7'd10));
            if (w_value < 7'd10) w_tens_seg = SEG_BLANK;
            else                 w_tens_seg = digit_to_seg(4'(w_value / 7'd10));
        end

        if (w_state_nx == OFF)  w_digit_sel_nx = 1'b0;
        else if (w_scan_tick)   w_digit_sel_nx = ~r_digit_sel;
        else                    w_digit_sel_nx = r_digit_sel;

        if (w_state_nx == OFF)  w_an_nx = 2'b00;
        else if (w_digit_sel_nx) w_an_nx = 2'b10;
        else                    w_an_nx = 2'b01;

        if ((w_state_nx == OFF) || w_phase_nx) w_seg_nx = SEG_BLANK;
        else if (w_digit_sel_nx)              w_seg_nx = w_tens_seg;
        else                                  w_seg_nx = w_ones_seg;
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_floor_q   <= '0;
            r_state     <= OFF;
            r_digit_sel <= 1'b0;
            r_phase     <= 1'b0;
            r_dark_cnt  <= '0;
            r_seg       <= SEG_BLANK;
            r_an        <= 2'b00;
            r_blinking  <= 1'b0;
        end else begin
            r_floor_q   <= floor;
            r_state     <= w_state_nx;
            r_digit_sel <= w_digit_sel_nx;
            r_phase     <= w_phase_nx;
            r_dark_cnt  <= w_dark_nx;
            r_seg       <= w_seg_nx;
            r_an        <= w_an_nx;
            r_blinking  <= w_blink_nx;
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign blinking = r_blinking;

endmodule

// File: tb/tb_elevator_floor_display.sv
// Directed bench for elevator_floor_display with small test parameters.
module tb_elevator_floor_display;

    localparam logic [6:0] E_BLANK = 7'b0000000;
    localparam logic [6:0] E_1     = 7'b0000110;
    localparam logic [6:0] E_3     = 7'b1001111;
    localparam logic [6:0] E_DASH  = 7'b1000000;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] floor;
    logic       arrive;
    logic       alarm;
    logic [6:0] seg;
    logic [1:0] an;
    logic       blinking;

    int n_total = 0;
    int n_bad   = 0;
    int n_en    = 0;

    always #5 clock = ~clock;

    elevator_floor_display #(
        .NUM_FLOORS  (12),
        .FLOOR_W     (4),
        .FLOOR_BASE  (1),
        .SCAN_DIV    (2),
        .BLINK_DIV   (4),
        .BLINK_COUNT (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .floor    (floor),
        .arrive   (arrive),
        .alarm    (alarm),
        .seg      (seg),
        .an       (an),
        .blinking (blinking)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // One clock; n_en counts edges since the display was switched on.
    task automatic step();
        @(posedge clock);
        if (reset || !enable) n_en = 0;
        else                  n_en++;
        @(negedge clock);
    endtask

    task automatic chk_disp(input string tag, input logic [6:0] ones, input logic [6:0] tens,
                            input bit dark, input bit blink);
        logic [1:0] e_an;
        logic [6:0] e_seg;
        if (n_en == 0)                      e_an = 2'b00;
        else if ((((n_en - 1) / 2) % 2) == 1) e_an = 2'b10;
        else                                e_an = 2'b01;
        if (n_en == 0 || dark)  e_seg = E_BLANK;
        else if (e_an == 2'b10) e_seg = tens;
        else                    e_seg = ones;
        check({tag, ".an"},    32'(an),       32'(e_an));
        check({tag, ".seg"},   32'(seg),      32'(e_seg));
        check({tag, ".blink"}, 32'(blinking), 32'(blink));
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        arrive = 1'b0;
        alarm  = 1'b0;
        floor  = 4'd0;
        step();
        step();
        check("rst.seg",   32'(seg),      32'd0);
        check("rst.an",    32'(an),       32'd0);
        check("rst.blink", 32'(blinking), 32'd0);

        // 1: floor 2 shows "3"; the first lit frame still decodes the reset floor
        floor  = 4'd2;
        enable = 1'b1;
        reset  = 1'b0;
        step();
        chk_disp("t1.first", E_1, E_BLANK, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_disp("t1.three", E_3, E_BLANK, 1'b0, 1'b0);
        end

        // 2: two-digit label, then an out-of-range code
        floor = 4'd10;
        step();
        chk_disp("t2.lag", E_3, E_BLANK, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_disp("t2.eleven", E_1, E_1, 1'b0, 1'b0);
        end
        floor = 4'd13;
        step();
        chk_disp("t2.lag2", E_1, E_1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_disp("t2.dash", E_DASH, E_DASH, 1'b0, 1'b0);
        end

        // 3: single arrival blink, lit 4 / dark 4 twice
        floor = 4'd2;
        step();
        chk_disp("t3.lag", E_DASH, E_DASH, 1'b0, 1'b0);
        step();
        chk_disp("t3.pre", E_3, E_BLANK, 1'b0, 1'b0);
        arrive = 1'b1;
        for (int j = 0; j < 16; j++) begin
            step();
            arrive = 1'b0;
            chk_disp("t3.blink", E_3, E_BLANK, ((j / 4) % 2) == 1, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk_disp("t3.done", E_3, E_BLANK, 1'b0, 1'b0);
        end

        // 4: second arrive six cycles later restarts the sequence
        arrive = 1'b1;
        for (int j = 0; j < 22; j++) begin
            step();
            arrive = (j == 5);
            if (j < 6) chk_disp("t4.first", E_3, E_BLANK, ((j / 4) % 2) == 1, 1'b1);
            else       chk_disp("t4.again", E_3, E_BLANK, (((j - 6) / 4) % 2) == 1, 1'b1);
        end
        step();
        chk_disp("t4.done", E_3, E_BLANK, 1'b0, 1'b0);

        // 5: alarm held 20 cycles, arrive at cycle 5 ignored, lit right after release
        alarm = 1'b1;
        for (int j = 0; j < 21; j++) begin
            step();
            arrive = (j == 4);
            alarm  = (j < 19);
            if (j < 20) chk_disp("t5.hold", E_3, E_BLANK, ((j / 4) % 2) == 1, 1'b1);
            else        chk_disp("t5.release", E_3, E_BLANK, 1'b0, 1'b0);
        end

        // 6: enable drop during a dark phase, then asynchronous reset mid-blink
        arrive = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            arrive = 1'b0;
            chk_disp("t6.blink", E_3, E_BLANK, ((j / 4) % 2) == 1, 1'b1);
        end
        enable = 1'b0;
        step();
        chk_disp("t6.off", E_3, E_BLANK, 1'b0, 1'b0);
        step();
        chk_disp("t6.off2", E_3, E_BLANK, 1'b0, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_disp("t6.on", E_3, E_BLANK, 1'b0, 1'b0);
        end
        arrive = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            arrive = 1'b0;
            chk_disp("t6.blink2", E_3, E_BLANK, ((j / 4) % 2) == 1, 1'b1);
        end
        reset = 1'b1;
        #1;
        check("t6.arst.seg",   32'(seg),      32'd0);
        check("t6.arst.an",    32'(an),       32'd0);
        check("t6.arst.blink", 32'(blinking), 32'd0);
        step();
        chk_disp("t6.inrst", E_3, E_BLANK, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_disp("t6.post1", E_1, E_BLANK, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_disp("t6.post", E_3, E_BLANK, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
